k_means_rd_sched: RTL



---
 rtl/k_means_rd_sched_pkg.sv | 29 ++
 rtl/k_means_rd_sched_if.sv | 28 ++
 rtl/k_means_req_chunker.sv | 58 +++++
 rtl/k_means_rd_sched.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/k_means_rd_sched_pkg.sv
// Shared types and constants for the k-means read scheduler.
// Provides the host bus widths, the default feature size, the scheduler
// state encoding and a ceiling divide by a power of two.
package k_means_rd_sched_pkg;

    localparam int unsigned AXI_DATA_BITS      = 512;
    localparam int unsigned LEN_BITS           = 28;
    localparam int unsigned NUM_CLUSTER_BITS   = 8;
    localparam int unsigned MAX_DEPTH_BITS     = 8;
    localparam int unsigned FEAT_BYTES_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_REQ_CENT,
        ST_REQ_DATA,
        ST_WAIT,
        ST_DONE
    } kmeans_sched_state_t;

    // ceil(bytes / 2**shift) without a 65-bit intermediate sum
    function automatic logic [63:0] ceil_div_pow2(input logic [63:0] bytes,
                                                  input int unsigned shift);
        logic [63:0] mask;
        mask = (64'd1 << shift) - 64'd1;
        return (bytes >> shift) + {63'd0, |(bytes & mask)};
    endfunction

endpackage

// File: rtl/k_means_rd_sched_if.sv
// Host read-request channel plus the monitored data-stream handshake.
//   rd_req_valid/ready : request handshake
//   rd_req_vaddr/len   : request address and byte count
//   rd_req_last        : final request of the operation
//   beat_valid/ready   : data stream handshake being counted
// master = scheduler side, slave = host/stream side.
interface k_means_rd_sched_if;
    import k_means_rd_sched_pkg::*;

    logic                rd_req_valid;
    logic                rd_req_ready;
    logic [63:0]         rd_req_vaddr;
    logic [LEN_BITS-1:0] rd_req_len;
    logic                rd_req_last;
    logic                beat_valid;
    logic                beat_ready;

    modport master (
        output rd_req_valid, rd_req_vaddr, rd_req_len, rd_req_last,
        input  rd_req_ready, beat_valid, beat_ready
    );

    modport slave (
        input  rd_req_valid, rd_req_vaddr, rd_req_len, rd_req_last,
        output rd_req_ready, beat_valid, beat_ready
    );

endinterface

// File: rtl/k_means_req_chunker.sv
// Splits a byte range into read requests of at most MAX_XFER_BYTES.
//   clk, rst_n : clock, async active-low reset
//   i_load     : load a new range (i_base, i_bytes); zero bytes stays idle
//   i_ready    : downstream accepts the current chunk
//   o_valid    : a chunk is pending
//   o_vaddr    : chunk address (base + bytes already issued)
//   o_len      : chunk length, min(MAX_XFER_BYTES, remaining)
//   o_final    : the pending chunk is the last of the range
module k_means_req_chunker #(
    parameter int unsigned MAX_XFER_BYTES = 4096,
    parameter int unsigned LEN_BITS       = 28
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic [63:0]         i_base,
    input  logic [63:0]         i_bytes,
    input  logic                i_ready,
    output logic                o_valid,
    output logic [63:0]         o_vaddr,
    output logic [LEN_BITS-1:0] o_len,
    output logic                o_final
);

    localparam logic [63:0] MAX64 = 64'(MAX_XFER_BYTES);

    logic        r_valid;
    logic [63:0] r_vaddr;
    logic [63:0] r_rem;
    logic [63:0] w_len64;
    logic        w_fire;

    assign w_len64 = (r_rem > MAX64) ? MAX64 : r_rem;
    assign w_fire  = r_valid & i_ready;

    // The address register carries base + offset directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_vaddr <= '0;
            r_rem   <= '0;
        end else if (i_load) begin
            r_valid <= (i_bytes != 64'd0);
            r_vaddr <= i_base;
            r_rem   <= i_bytes;
        end else if (w_fire) begin
            r_valid <= (r_rem != w_len64);
            r_vaddr <= r_vaddr + w_len64;
            r_rem   <= r_rem - w_len64;
        end
    end

    assign o_valid = r_valid;
    assign o_vaddr = r_vaddr;
    assign o_len   = w_len64[LEN_BITS-1:0];
    assign o_final = r_valid && (r_rem <= MAX64);

endmodule

// File: rtl/k_means_rd_sched.sv
// k-means read scheduler: on start_operator latches the job parameters,
// issues chunked host reads (centroids, then data set), counts returning
// stream beats and pulses um_done once all requested beats have arrived.
//   aclk, aresetn                : clock, async active-low reset
//   start_operator               : single-cycle start (ignored while busy)
//   num_clusters, data_dim       : job shape
//   data_set_size                : number of points
//   centroid_addr, data_addr     : host virtual bases
//   rd_bus                       : read request + monitored beat handshake
//   busy                         : operation in progress
//   um_done                      : single-cycle completion pulse
module k_means_rd_sched
    import k_means_rd_sched_pkg::*;
#(
    parameter int unsigned MAX_XFER_BYTES = 4096,
    parameter int unsigned BEAT_BYTES     = AXI_DATA_BITS / 8,
    parameter int unsigned FEAT_BYTES     = FEAT_BYTES_DEFAULT
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      start_operator,
    input  logic [NUM_CLUSTER_BITS:0] num_clusters,
    input  logic [MAX_DEPTH_BITS:0]   data_dim,
    input  logic [63:0]               data_set_size,
    input  logic [63:0]               centroid_addr,
    input  logic [63:0]               data_addr,
    k_means_rd_sched_if.master        rd_bus,
    output logic                      busy,
    output logic                      um_done
);

    localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);

    kmeans_sched_state_t       r_state;
    logic [NUM_CLUSTER_BITS:0] r_num_clusters;
    logic [MAX_DEPTH_BITS:0]   r_data_dim;
    logic [63:0]               r_set_size;
    logic [63:0]               r_cent_addr;
    logic [63:0]               r_data_addr;
    logic [63:0]               r_data_bytes;
    logic [63:0]               r_total_beats;
    logic [63:0]               r_beat_cnt;
    logic                      r_last_phase;
    logic                      r_busy;
    logic                      r_um_done;

    logic [63:0]         w_cent_bytes;
    logic [63:0]         w_data_bytes;
    logic [63:0]         w_total_beats;
    logic                w_beat_fire;
    logic                w_chunk_valid;
    logic                w_chunk_final;
    logic                w_req_fire;
    logic                w_load;
    logic [63:0]         w_load_base;
    logic [63:0]         w_load_bytes;
    logic [63:0]         w_vaddr;
    logic [LEN_BITS-1:0] w_len;

    assign w_cent_bytes  = 64'(r_num_clusters) * 64'(r_data_dim) * 64'(FEAT_BYTES);
    assign w_data_bytes  = r_set_size * 64'(r_data_dim) * 64'(FEAT_BYTES);
    assign w_total_beats = ceil_div_pow2(w_cent_bytes, BEAT_SHIFT)
                         + ceil_div_pow2(w_data_bytes, BEAT_SHIFT);

    assign w_beat_fire = rd_bus.beat_valid & rd_bus.beat_ready;
    assign w_req_fire  = w_chunk_valid & rd_bus.rd_req_ready;

    // The single chunker is loaded from CALC with the first non-empty range,
    // and reloaded with the data range on the last centroid handshake so the
    // request stream continues without a bubble.
    always_comb begin
        w_load       = 1'b0;
        w_load_base  = '0;
        w_load_bytes = '0;
        case (r_state)
            ST_CALC: begin
                if (w_total_beats != 64'd0) begin
                    w_load = 1'b1;
                    if (w_cent_bytes != 64'd0) begin
                        w_load_base  = r_cent_addr;
                        w_load_bytes = w_cent_bytes;
                    end else begin
                        w_load_base  = r_data_addr;
                        w_load_bytes = w_data_bytes;
                    end
                end
            end
            ST_REQ_CENT: begin
                if (w_req_fire && w_chunk_final && (r_data_bytes != 64'd0)) begin
                    w_load       = 1'b1;
                    w_load_base  = r_data_addr;
                    w_load_bytes = r_data_bytes;
                end
            end
            default: ;
        endcase
    end

    k_means_req_chunker #(
        .MAX_XFER_BYTES (MAX_XFER_BYTES),
        .LEN_BITS       (LEN_BITS)
    ) u_chunker (
        .clk     (aclk),
        .rst_n   (aresetn),
        .i_load  (w_load),
        .i_base  (w_load_base),
        .i_bytes (w_load_bytes),
        .i_ready (rd_bus.rd_req_ready),
        .o_valid (w_chunk_valid),
        .o_vaddr (w_vaddr),
        .o_len   (w_len),
        .o_final (w_chunk_final)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state        <= ST_IDLE;
            r_num_clusters <= '0;
            r_data_dim     <= '0;
            r_set_size     <= '0;
            r_cent_addr    <= '0;
            r_data_addr    <= '0;
            r_data_bytes   <= '0;
            r_total_beats  <= '0;
            r_beat_cnt     <= '0;
            r_last_phase   <= 1'b0;
            r_busy         <= 1'b0;
            r_um_done      <= 1'b0;
        end else begin
            r_um_done <= 1'b0;
            if (w_beat_fire && (r_state != ST_IDLE) && (r_state != ST_CALC))
                r_beat_cnt <= r_beat_cnt + 64'd1;

            case (r_state)
                ST_IDLE: begin
                    if (start_operator) begin
                        r_num_clusters <= num_clusters;
                        r_data_dim     <= data_dim;
                        r_set_size     <= data_set_size;
                        r_cent_addr    <= centroid_addr;
                        r_data_addr    <= data_addr;
                        r_beat_cnt     <= '0;
                        r_busy         <= 1'b1;
                        r_state        <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_data_bytes  <= w_data_bytes;
                    r_total_beats <= w_total_beats;
                    // Only one phase left to issue: its final chunk is the last overall.
                    r_last_phase  <= (w_cent_bytes == 64'd0) || (w_data_bytes == 64'd0);
                    if (w_total_beats == 64'd0) begin
                        r_state   <= ST_DONE;
                        r_um_done <= 1'b1;
                    end else if (w_cent_bytes == 64'd0) begin
                        r_state <= ST_REQ_DATA;
                    end else begin
                        r_state <= ST_REQ_CENT;
                    end
                end
                ST_REQ_CENT: begin
                    if (w_req_fire && w_chunk_final) begin
                        if (r_data_bytes == 64'd0) begin
                            r_state <= ST_WAIT;
                        end else begin
                            r_state      <= ST_REQ_DATA;
                            r_last_phase <= 1'b1;
                        end
                    end
                end
                ST_REQ_DATA: begin
                    if (w_req_fire && w_chunk_final)
                        r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_beat_cnt == r_total_beats) begin
                        r_state   <= ST_DONE;
                        r_um_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rd_bus.rd_req_valid = w_chunk_valid;
    assign rd_bus.rd_req_vaddr = w_vaddr;
    assign rd_bus.rd_req_len   = w_len;
    assign rd_bus.rd_req_last  = w_chunk_final && r_last_phase;
    assign busy                = r_busy;
    assign um_done             = r_um_done;

endmodule
